// File: rtl/fp16_pkg.sv
// Shared FP16 constants: class codes, one-hot bit positions, field
// widths, per-class population sizes and the generator FSM encoding.
package fp16_pkg;

    localparam int W_FLOAT = 16;
    localparam int W_SIGN  = 1;
    localparam int W_EXP   = 5;
    localparam int W_MANT  = 10;

    localparam logic [W_EXP-1:0] EXP_MAX  = 5'd31;
    localparam int               QNAN_BIT = 9;

    localparam logic [2:0] CLS_SNAN   = 3'd0;
    localparam logic [2:0] CLS_QNAN   = 3'd1;
    localparam logic [2:0] CLS_INF    = 3'd2;
    localparam logic [2:0] CLS_ZERO   = 3'd3;
    localparam logic [2:0] CLS_SUB    = 3'd4;
    localparam logic [2:0] CLS_NORMAL = 3'd5;

    // one-hot layout {snan,qnan,inf,zero,subnormal,normal}
    localparam int OH_SNAN   = 5;
    localparam int OH_QNAN   = 4;
    localparam int OH_INF    = 3;
    localparam int OH_ZERO   = 2;
    localparam int OH_SUB    = 1;
    localparam int OH_NORMAL = 0;

    localparam logic [15:0] M_SNAN   = 16'd1022;
    localparam logic [15:0] M_QNAN   = 16'd1024;
    localparam logic [15:0] M_INF    = 16'd2;
    localparam logic [15:0] M_ZERO   = 16'd2;
    localparam logic [15:0] M_SUB    = 16'd2046;
    localparam logic [15:0] M_NORMAL = 16'd61440;

    localparam logic [15:0] H_SNAN   = 16'd511;
    localparam logic [15:0] H_QNAN   = 16'd512;
    localparam logic [15:0] H_INF    = 16'd1;
    localparam logic [15:0] H_ZERO   = 16'd1;
    localparam logic [15:0] H_SUB    = 16'd1023;
    localparam logic [15:0] H_NORMAL = 16'd30720;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE   = 1'b0;
    localparam state_t ST_STREAM = 1'b1;

    function automatic logic [15:0] class_size(input logic [2:0] c);
        case (c)
            CLS_SNAN:   return M_SNAN;
            CLS_QNAN:   return M_QNAN;
            CLS_INF:    return M_INF;
            CLS_ZERO:   return M_ZERO;
            CLS_SUB:    return M_SUB;
            CLS_NORMAL: return M_NORMAL;
            default:    return 16'd0;
        endcase
    endfunction

    function automatic logic [15:0] class_half(input logic [2:0] c);
        case (c)
            CLS_SNAN:   return H_SNAN;
            CLS_QNAN:   return H_QNAN;
            CLS_INF:    return H_INF;
            CLS_ZERO:   return H_ZERO;
            CLS_SUB:    return H_SUB;
            CLS_NORMAL: return H_NORMAL;
            default:    return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/fp16_class_encode.sv
// Combinational index -> encoding map for one FP16 class.
// Ports: cls_i class code, idx_i member index; float_o encoding, class_o one-hot.
module fp16_class_encode
    import fp16_pkg::*;
(
    input  logic [2:0]  cls_i,
    input  logic [15:0] idx_i,
    output logic [15:0] float_o,
    output logic [5:0]  class_o
);

    logic [15:0]       half;
    logic              sign;
    logic [14:0]       k;
    logic [W_EXP-1:0]  exp_f;
    logic [W_MANT-1:0] mant_f;

    // first half of the index range is the positive members
    always_comb begin
        half = class_half(cls_i);
        sign = (idx_i >= half);
        k    = 15'(idx_i - (sign ? half : 16'd0));
    end

    always_comb begin
        exp_f   = '0;
        mant_f  = '0;
        class_o = '0;
        case (cls_i)
            CLS_SNAN: begin
                exp_f            = EXP_MAX;
                mant_f           = k[9:0] + 10'd1;
                class_o[OH_SNAN] = 1'b1;
            end
            CLS_QNAN: begin
                exp_f            = EXP_MAX;
                mant_f[QNAN_BIT] = 1'b1;
                mant_f[8:0]      = k[8:0];
                class_o[OH_QNAN] = 1'b1;
            end
            CLS_INF: begin
                exp_f           = EXP_MAX;
                class_o[OH_INF] = 1'b1;
            end
            CLS_ZERO: begin
                class_o[OH_ZERO] = 1'b1;
            end
            CLS_SUB: begin
                mant_f          = k[9:0] + 10'd1;
                class_o[OH_SUB] = 1'b1;
            end
            CLS_NORMAL: begin
                exp_f              = k[14:10] + 5'd1;
                mant_f             = k[9:0];
                class_o[OH_NORMAL] = 1'b1;
            end
            default: ;
        endcase
    end

    assign float_o = {sign, exp_f, mant_f};

endmodule

// File: rtl/fp16_class_generator.sv
// Streams every (or count_i) FP16 encodings of one class with expected one-hot.
// Ports: req_* request handshake, out_* beat stream, err_o illegal-class pulse.
module fp16_class_generator
    import fp16_pkg::*;
#(
    parameter int W_CNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       cls_i,
    input  logic [W_CNT-1:0] count_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [15:0]      float_o,
    output logic [5:0]       class_o,
    output logic             last_o,
    output logic             err_o
);

    localparam logic [W_CNT-1:0] ONE = W_CNT'(1);

    state_t           state_q, state_d;
    logic [2:0]       cls_q, cls_d;
    logic [W_CNT-1:0] idx_q, idx_d;
    logic [W_CNT-1:0] rem_q, rem_d;
    logic             valid_q, valid_d;
    logic [15:0]      float_q, float_d;
    logic [5:0]       class_q, class_d;
    logic             last_q, last_d;
    logic             err_q, err_d;

    logic [W_CNT-1:0] size_cur, size_new, idx_nxt;
    logic [2:0]       enc_cls;
    logic [W_CNT-1:0] enc_idx;
    logic [15:0]      enc_float;
    logic [5:0]       enc_class;
    logic             cls_ok;

    assign size_cur = W_CNT'(class_size(cls_q));
    assign size_new = W_CNT'(class_size(cls_i));
    assign idx_nxt  = (idx_q == size_cur - ONE) ? '0 : idx_q + ONE;
    assign cls_ok   = (cls_i <= CLS_NORMAL);

    // encoder sees the beat that will be registered at the next edge
    always_comb begin
        enc_cls = cls_q;
        enc_idx = idx_nxt;
        if (state_q == ST_IDLE) begin
            enc_cls = cls_i;
            enc_idx = '0;
        end
    end

    fp16_class_encode u_enc (
        .cls_i   (enc_cls),
        .idx_i   (16'(enc_idx)),
        .float_o (enc_float),
        .class_o (enc_class)
    );

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        float_d = float_q;
        class_d = class_q;
        last_d  = last_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (cls_ok) begin
                        state_d = ST_STREAM;
                        cls_d   = cls_i;
                        idx_d   = '0;
                        rem_d   = (count_i == '0) ? size_new : count_i;
                        valid_d = 1'b1;
                        float_d = enc_float;
                        class_d = enc_class;
                        last_d  = (rem_d == ONE);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (out_ready_i) begin
                    if (rem_q == ONE) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        rem_d   = rem_q - ONE;
                        idx_d   = idx_nxt;
                        float_d = enc_float;
                        class_d = enc_class;
                        last_d  = (rem_d == ONE);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cls_q   <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            float_q <= '0;
            class_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            float_q <= float_d;
            class_q <= class_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign out_valid_o = valid_q;
    assign float_o     = float_q;
    assign class_o     = class_q;
    assign last_o      = last_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_fp16_class_generator.sv
// Scoreboard bench: reference lists built by classifying all 65536 encodings,
// a negedge monitor compares every presented beat against the queue head.
module tb_fp16_class_generator;

    typedef struct packed {
        logic [15:0] f;
        logic [5:0]  c;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  cls_i = '0;
    logic [15:0] count_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [15:0] float_o;
    logic [5:0]  class_o;
    logic        last_o;
    logic        err_o;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;

    beat_t       sb[$];
    logic [15:0] lists[6][$];

    always #5 clk = ~clk;

    fp16_class_generator #(.W_CNT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .cls_i       (cls_i),
        .count_i     (count_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .float_o     (float_o),
        .class_o     (class_o),
        .last_o      (last_o),
        .err_o       (err_o)
    );

    // class code straight from the IEEE-754 field rules
    function automatic int classify(input logic [15:0] f);
        int e, m;
        e = int'(f[14:10]);
        m = int'(f[9:0]);
        if (e == 31) begin
            if (m == 0) return 2;
            return (m >= 512) ? 1 : 0;
        end
        if (e == 0) return (m == 0) ? 3 : 4;
        return 5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    // expected beats: list is positive members then negative, wrap on count
    task automatic push_req(input int c, input int cnt);
        int sz, n;
        beat_t b;
        sz = lists[c].size();
        n  = (cnt == 0) ? sz : cnt;
        for (int i = 0; i < n; i++) begin
            b.f = lists[c][i % sz];
            b.c = 6'(1 << (5 - c));
            b.l = (i == n - 1);
            sb.push_back(b);
        end
    endtask

    task automatic issue(input int c, input int cnt);
        @(posedge clk);
        #1;
        req_valid_i = 1'b1;
        cls_i       = 3'(c);
        count_i     = 16'(cnt);
        if (c <= 5) push_req(c, cnt);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    // mode 0: ready held high, mode 1: rare pseudo-random stalls
    task automatic drain(input string nm, input int mode, input int budget);
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < budget) begin
            out_ready_i = (mode == 0) ? 1'b1 : ($urandom_range(0, 15) != 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout got %0d left expected 0", nm, sb.size());
            sb.delete();
        end
        @(negedge clk);
        chk({nm, "_ready_after"}, 32'(req_ready_o), 32'd1);
        chk({nm, "_valid_after"}, 32'(out_valid_o), 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        beat_t e;
        if (!rst && out_valid_o) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_beat got %h expected none", float_o);
            end else begin
                e = sb[0];
                if (float_o !== e.f || class_o !== e.c || last_o !== e.l
                    || req_ready_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL beat%0d got f=%h c=%b l=%b rdy=%b expected f=%h c=%b l=%b rdy=0",
                             n_pop, float_o, class_o, last_o, req_ready_o,
                             e.f, e.c, e.l);
                end
                if (out_ready_i) begin
                    void'(sb.pop_front());
                    n_pop++;
                end
            end
        end else if (!rst && last_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL last_without_valid got 1 expected 0");
        end
    end

    initial begin
        int p0;
        for (int v = 0; v < 65536; v++) begin
            if (v < 32768) lists[classify(16'(v))].push_back(16'(v));
        end
        for (int v = 32768; v < 65536; v++) begin
            lists[classify(16'(v))].push_back(16'(v));
        end

        // 1: reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_float", 32'(float_o), 32'h0000);
        chk("rst_class", 32'(class_o), 32'd0);
        chk("rst_last", 32'(last_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 2: inf full class
        out_ready_i = 1'b1;
        p0 = n_pop;
        issue(2, 0);
        drain("inf", 0, 100);
        chk("inf_beats", 32'(n_pop - p0), 32'd2);

        // 3: snan full class
        p0 = n_pop;
        issue(0, 0);
        drain("snan", 0, 2000);
        chk("snan_beats", 32'(n_pop - p0), 32'd1022);

        // 4: zero with wrap
        p0 = n_pop;
        issue(3, 5);
        drain("zero", 0, 100);
        chk("zero_beats", 32'(n_pop - p0), 32'd5);

        // 5: normal full class with stalls
        p0 = n_pop;
        out_ready_i = 1'b0;
        issue(5, 0);
        drain("normal", 1, 90000);
        chk("normal_beats", 32'(n_pop - p0), 32'd61440);

        // 6: illegal class then reset mid-stream
        issue(7, 0);
        @(negedge clk);
        chk("err_pulse", 32'(err_o), 32'd1);
        chk("err_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk);
        chk("err_clear", 32'(err_o), 32'd0);
        chk("err_novalid", 32'(out_valid_o), 32'd0);

        out_ready_i = 1'b1;
        p0 = n_pop;
        issue(4, 0);
        for (int c = 0; c < 200 && (n_pop - p0) < 10; c++) begin
            @(posedge clk);
            #1;
        end
        chk("sub_pre_rst_beats", 32'(n_pop - p0), 32'd10);
        out_ready_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid_o), 32'd0);
        chk("midrst_ready", 32'(req_ready_o), 32'd1);
        chk("midrst_last", 32'(last_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_valid", 32'(out_valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
